// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline controller state and fixed latch indices.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pipe_state_t;

   localparam int PC_IDX   = 0;
   localparam int IFID_IDX = 1;
   localparam int IDEX_IDX = 2;

endpackage

// File: rtl/pipeline_perf_cnt.sv
// Free-running pipeline performance counters; all freeze while run_i is low.
module pipeline_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             run_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             instr_i,
   output logic [CNT_W-1:0] cyc_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   localparam logic [CNT_W-1:0] INC = CNT_W'(1);

   logic [CNT_W-1:0] cyc_q, cyc_d, stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d, instr_q, instr_d;

   always_comb begin
      cyc_d   = cyc_q;
      stall_d = stall_q;
      flush_d = flush_q;
      instr_d = instr_q;
      if (run_i) begin
         cyc_d = cyc_q + INC;
         if (stall_i) stall_d = stall_q + INC;
         if (flush_i) flush_d = flush_q + INC;
         if (instr_i) instr_d = instr_q + INC;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cyc_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
         instr_q <= '0;
      end else begin
         cyc_q   <= cyc_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
         instr_q <= instr_d;
      end
   end

   assign cyc_cnt_o   = cyc_q;
   assign stall_cnt_o = stall_q;
   assign flush_cnt_o = flush_q;
   assign instr_cnt_o = instr_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stage sequencer: latch valid bits, enables/flushes and halt FSM.
// Define PIPE_PERF_CNT_EN to add the cyc/stall/flush/instr performance counters.
module pipeline_controller
   import cpu_types_pkg::*;
#(
   parameter int STAGES         = 5,
   parameter int REDIRECT_STAGE = 3,
   parameter int CNT_W          = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              mem_req,
   input  logic              load_use,
   input  logic              redirect,
   input  logic              halt_dec,
   input  logic              halt_in,
   output logic [STAGES-1:0] stage_en,
   output logic [STAGES-1:0] stage_flush,
   output logic [STAGES-1:0] valid,
   output logic              imem_ren,
   output logic              halted
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  cyc_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  instr_cnt
`endif
);

   generate
      if (STAGES < 4 || REDIRECT_STAGE < 2 || REDIRECT_STAGE > STAGES - 2 || CNT_W < 1) begin : g_bad_param
         $error("pipeline_controller: illegal STAGES/REDIRECT_STAGE/CNT_W");
      end
   endgenerate

   localparam logic [STAGES-1:0] ONE        = STAGES'(1);
   localparam logic [STAGES-1:0] REDIR_MASK = ((ONE << (REDIRECT_STAGE + 1)) - ONE) & ~ONE;

   pipe_state_t       state_q, state_d;
   logic [STAGES-1:1] valid_q, valid_d;
   logic [STAGES-1:0] en, fl;
   logic              mem_busy, mstall;

   assign valid    = {valid_q, state_q == RUN};
   assign mem_busy = mem_req & valid[STAGES-2];
   assign mstall   = mem_busy & ~dhit;

   // Single priority chain: halt > data stall > redirect > load-use > fetch stall/drain.
   always_comb begin
      en = '0;
      fl = '0;
      if (!nRST) begin
         fl = ~ONE;
      end else if (state_q != HALTED && !mstall) begin
         if (redirect) begin
            en = '1;
            fl = REDIR_MASK;
         end else if (load_use) begin
            en = ~(ONE | (ONE << IFID_IDX));
            fl = ONE << IDEX_IDX;
         end else if (!ihit || state_q == DRAIN) begin
            en = ~ONE;
            fl = ONE << IFID_IDX;
         end else begin
            en = '1;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      for (int k = 1; k < STAGES; k++) begin
         if (fl[k])      valid_d[k] = 1'b0;
         else if (en[k]) valid_d[k] = valid[k-1];
      end
   end

   // halt_in is checked first so a simultaneous redirect cannot rescue a retiring halt.
   always_comb begin
      state_d = state_q;
      if (!mstall) begin
         case (state_q)
            RUN: begin
               if (halt_in && valid[STAGES-1])                   state_d = HALTED;
               else if (halt_dec && valid[IFID_IDX] && !redirect) state_d = DRAIN;
            end
            DRAIN: begin
               if (halt_in && valid[STAGES-1]) state_d = HALTED;
               else if (redirect)              state_d = RUN;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= RUN;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

   assign stage_en    = en;
   assign stage_flush = fl;
   assign imem_ren    = nRST & (state_q == RUN) & ~mem_busy;
   assign halted      = nRST & (state_q == HALTED);

`ifdef PIPE_PERF_CNT_EN
   logic stall_ev, flush_ev, instr_ev;

   assign stall_ev = mstall | (~redirect & (load_use | ~ihit));
   assign flush_ev = redirect & ~mstall;
   assign instr_ev = valid[STAGES-1] & (en[STAGES-1] | (state_d == HALTED && state_q != HALTED));

   pipeline_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .CLK         (CLK),
      .nRST        (nRST),
      .run_i       (state_q != HALTED),
      .stall_i     (stall_ev),
      .flush_i     (flush_ev),
      .instr_i     (instr_ev),
      .cyc_cnt_o   (cyc_cnt),
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt),
      .instr_cnt_o (instr_cnt)
   );
`endif

endmodule
